// File: rtl/mvm_input_loader.sv
// mvm_input_loader: front-end initiator for the matrix-vector multiplier.
// Accepts a 20-beat framed operand stream on a valid/ready interface, writes
// beats 0..15 into the X memory and beats 16..19 into the A memory, then
// pulses start and holds off new input until the control module reports done.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   in_valid/in_ready     upstream beat handshake (in_ready decoded from state)
//   in_data, in_last      operand value, end-of-frame marker (beat 20)
//   addr_x/wr_en_x/data_x X memory write port (registered)
//   addr_a/wr_en_a/data_a A memory write port (registered)
//   start, done           one-cycle start pulse / completion from control
//   busy                  frame in flight until done is seen
//   frame_err             one-cycle pulse on a misplaced or missing in_last
module mvm_input_loader #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic [3:0]       addr_x,
  output logic             wr_en_x,
  output logic [WIDTH-1:0] data_x,
  output logic [1:0]       addr_a,
  output logic             wr_en_a,
  output logic [WIDTH-1:0] data_a,
  output logic             start,
  input  logic             done,
  output logic             busy,
  output logic             frame_err
);

  localparam int unsigned CNT_W = 5;
  localparam logic [CNT_W-1:0] X_BEATS   = CNT_W'(16);
  localparam logic [CNT_W-1:0] LAST_X    = CNT_W'(15);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(19);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_X    = 3'd1,
    LOAD_A    = 3'd2,
    FIRE      = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [3:0]       addr_x_next;
  logic             wr_en_x_next;
  logic [WIDTH-1:0] data_x_next;
  logic [1:0]       addr_a_next;
  logic             wr_en_a_next;
  logic [WIDTH-1:0] data_a_next;
  logic             start_next;
  logic             busy_next;
  logic             frame_err_next;
  logic             accept;
  logic             is_final;
  logic             bad_frame;

  // Ready is a pure decode of the state register
  assign in_ready  = (state == LOAD_X) || (state == LOAD_A);
  assign accept    = in_valid && in_ready;
  assign is_final  = (cnt == LAST_BEAT);
  // in_last must appear on beat 19 and nowhere else
  assign bad_frame = (in_last != is_final);

  // State and all registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_x    <= '0;
      wr_en_x   <= 1'b0;
      data_x    <= '0;
      addr_a    <= '0;
      wr_en_a   <= 1'b0;
      data_a    <= '0;
      start     <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      addr_x    <= addr_x_next;
      wr_en_x   <= wr_en_x_next;
      data_x    <= data_x_next;
      addr_a    <= addr_a_next;
      wr_en_a   <= wr_en_a_next;
      data_a    <= data_a_next;
      start     <= start_next;
      busy      <= busy_next;
      frame_err <= frame_err_next;
    end
  end

  // Next-state, beat counter and next values of the registered outputs
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    addr_x_next    = addr_x;
    wr_en_x_next   = 1'b0;
    data_x_next    = data_x;
    addr_a_next    = addr_a;
    wr_en_a_next   = 1'b0;
    data_a_next    = data_a;
    start_next     = 1'b0;
    busy_next      = busy;
    frame_err_next = 1'b0;

    case (state)
      IDLE: state_next = LOAD_X;

      LOAD_X, LOAD_A: begin
        if (accept) begin
          // The beat is always written, even when it breaks framing
          if (cnt < X_BEATS) begin
            wr_en_x_next = 1'b1;
            addr_x_next  = cnt[3:0];
            data_x_next  = in_data;
          end else begin
            wr_en_a_next = 1'b1;
            addr_a_next  = 2'(cnt - X_BEATS);
            data_a_next  = in_data;
          end

          if (bad_frame) begin
            frame_err_next = 1'b1;
            cnt_next       = '0;
            busy_next      = 1'b0;
            state_next     = LOAD_X;
          end else if (is_final) begin
            busy_next  = 1'b1;
            state_next = FIRE;
          end else begin
            cnt_next  = CNT_W'(cnt + CNT_W'(1));
            busy_next = 1'b1;
            if (cnt == LAST_X) state_next = LOAD_A;
          end
        end
      end

      // start registers here so the last A write has already committed
      FIRE: begin
        start_next = 1'b1;
        state_next = WAIT_DONE;
      end

      WAIT_DONE: begin
        if (done) begin
          cnt_next   = '0;
          busy_next  = 1'b0;
          state_next = LOAD_X;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mvm_input_loader.sv
// tb_mvm_input_loader: self-checking bench for mvm_input_loader.
// A frame-level reference model predicts every cycle's outputs; a short
// vector table and directed sequences cover framing errors, async reset,
// early done and back-to-back frames.
module tb_mvm_input_loader;
  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic [3:0]       addr_x;
  logic             wr_en_x;
  logic [WIDTH-1:0] data_x;
  logic [1:0]       addr_a;
  logic             wr_en_a;
  logic [WIDTH-1:0] data_a;
  logic             start;
  logic             done;
  logic             busy;
  logic             frame_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mvm_input_loader #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .addr_x(addr_x), .wr_en_x(wr_en_x), .data_x(data_x),
    .addr_a(addr_a), .wr_en_a(wr_en_a), .data_a(data_a),
    .start(start), .done(done), .busy(busy), .frame_err(frame_err)
  );

  // Reference model: frame position, readiness, pending start, waiting for done
  bit   m_idle, m_ready, m_fire, m_wait, m_busy;
  int   m_cnt;
  bit   e_wr_x, e_wr_a, e_start, e_ferr;
  logic [3:0] e_addr_x;
  logic [1:0] e_addr_a;
  logic [7:0] e_data;

  // Memory images rebuilt from observed writes
  logic [7:0] mem_x [16];
  logic [7:0] mem_a [4];
  int n_start, n_ferr;

  typedef struct {
    bit         v;
    logic [7:0] d;
    bit         last;
    bit         dn;
    bit         rdy;
    bit         wx;
    logic [3:0] ax;
    logic [7:0] dx;
    bit         ferr;
    bit         bsy;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_idle = 1; m_ready = 0; m_fire = 0; m_wait = 0; m_busy = 0; m_cnt = 0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem_x[i] = 'x;
    for (int i = 0; i < 4; i++) mem_a[i] = 'x;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  0);
    check({tag, "_wr_en_x"},   32'(wr_en_x),   0);
    check({tag, "_wr_en_a"},   32'(wr_en_a),   0);
    check({tag, "_addr_x"},    32'(addr_x),    0);
    check({tag, "_addr_a"},    32'(addr_a),    0);
    check({tag, "_data_x"},    32'(data_x),    0);
    check({tag, "_data_a"},    32'(data_a),    0);
    check({tag, "_start"},     32'(start),     0);
    check({tag, "_busy"},      32'(busy),      0);
    check({tag, "_frame_err"}, 32'(frame_err), 0);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    check_zero(tag);
    @(posedge clk); #1;
    reset = 1'b0;
    in_valid = 1'b0; in_last = 1'b0; done = 1'b0;
    model_reset();
  endtask

  // One clock: drive inputs, advance the model, compare after the edge
  task automatic tick(input bit v, input logic [7:0] d, input bit last, input bit dn);
    bit acc;
    in_valid = v; in_data = d; in_last = last; done = dn;
    check("in_ready", 32'(in_ready), 32'(m_ready));
    acc = v && m_ready;
    e_wr_x = 0; e_wr_a = 0; e_start = 0; e_ferr = 0;
    if (m_idle) begin
      m_idle = 0; m_ready = 1;
    end else if (acc) begin
      if (m_cnt < 16) begin e_wr_x = 1; e_addr_x = 4'(m_cnt); end
      else begin e_wr_a = 1; e_addr_a = 2'(m_cnt - 16); end
      e_data = d;
      if (last != (m_cnt == 19)) begin e_ferr = 1; m_cnt = 0; m_busy = 0; end
      else if (m_cnt == 19) begin m_cnt = 0; m_ready = 0; m_fire = 1; m_busy = 1; end
      else begin m_cnt++; m_busy = 1; end
    end else if (m_fire) begin
      e_start = 1; m_fire = 0; m_wait = 1;
    end else if (m_wait && dn) begin
      m_wait = 0; m_ready = 1; m_busy = 0;
    end
    @(posedge clk); #1;
    check("wr_en_x", 32'(wr_en_x), 32'(e_wr_x));
    check("wr_en_a", 32'(wr_en_a), 32'(e_wr_a));
    check("start", 32'(start), 32'(e_start));
    check("frame_err", 32'(frame_err), 32'(e_ferr));
    check("busy", 32'(busy), 32'(m_busy));
    if (e_wr_x) begin
      check("addr_x", 32'(addr_x), 32'(e_addr_x));
      check("data_x", 32'(data_x), 32'(e_data));
    end
    if (e_wr_a) begin
      check("addr_a", 32'(addr_a), 32'(e_addr_a));
      check("data_a", 32'(data_a), 32'(e_data));
    end
    if (wr_en_x) mem_x[addr_x] = data_x;
    if (wr_en_a) mem_a[addr_a] = data_a;
    if (start) n_start++;
    if (frame_err) n_ferr++;
  endtask

  // Send one frame of base+i data with optional gaps; err_beat>=0 puts in_last there
  task automatic send_frame(input logic [7:0] base, input int err_beat, input int gap_pct, input bit dn);
    int  i;
    int  budget;
    bit  v, last, will;
    i = 0;
    budget = 400;
    while (i < 20 && budget > 0) begin
      v    = int'($urandom_range(99)) >= gap_pct;
      last = (err_beat >= 0) ? (i == err_beat) : (i == 19);
      will = v && m_ready;
      if (v) tick(1'b1, base + 8'(i), last, dn);
      else   tick(1'b0, 8'($urandom), 1'($urandom), dn);
      if (will) i = (i == err_beat) ? 20 : i + 1;
      budget--;
    end
    check("frame_budget", 32'(budget > 0), 1);
  endtask

  task automatic check_mem(input string tag, input logic [7:0] base);
    for (int i = 0; i < 16; i++) check({tag, "_mem_x"}, 32'(mem_x[i]), 32'(base + 8'(i)));
    for (int i = 0; i < 4; i++)  check({tag, "_mem_a"}, 32'(mem_a[i]), 32'(base + 8'(16 + i)));
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; done = 1'b0;
    n_start = 0; n_ferr = 0;
    clear_mem();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("por");
    reset = 1'b0;

    // Vector table: idle cycle, gapped beats, in_last on beat 2, restart, done ignored
    tbl[0] = '{1'b1, 8'hA0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 8'h11, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 8'h99, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 4'h1, 8'h22, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b1, 4'h2, 8'h33, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 8'h44, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 1'b1, 4'h1, 8'h55, 1'b0, 1'b1};
    for (int k = 0; k < 8; k++) begin
      tick(tbl[k].v, tbl[k].d, tbl[k].last, tbl[k].dn);
      check("tbl_in_ready", 32'(in_ready), 32'(tbl[k].rdy));
      check("tbl_wr_en_x", 32'(wr_en_x), 32'(tbl[k].wx));
      if (tbl[k].wx) begin
        check("tbl_addr_x", 32'(addr_x), 32'(tbl[k].ax));
        check("tbl_data_x", 32'(data_x), 32'(tbl[k].dx));
      end
      check("tbl_frame_err", 32'(frame_err), 32'(tbl[k].ferr));
      check("tbl_busy", 32'(busy), 32'(tbl[k].bsy));
    end

    // Full frame with in_valid held high, data 1..20
    do_reset("rst1");
    clear_mem(); n_start = 0;
    send_frame(8'd1, -1, 0, 1'b0);
    repeat (5) tick(1'b0, 8'h00, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    check_mem("full", 8'd1);
    check("full_starts", 32'(n_start), 1);

    // Same data with ~50% gaps
    clear_mem(); n_start = 0;
    send_frame(8'd1, -1, 50, 1'b0);
    repeat (4) tick(1'b0, 8'h00, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    check_mem("gaps", 8'd1);
    check("gaps_starts", 32'(n_start), 1);

    // in_last on beat 7: error, no start, then a clean frame
    n_start = 0; n_ferr = 0;
    send_frame(8'h40, 7, 30, 1'b0);
    repeat (3) tick(1'b0, 8'h00, 1'b0, 1'b0);
    check("err_ferr_count", 32'(n_ferr), 1);
    check("err_no_start", 32'(n_start), 0);
    check("err_busy", 32'(busy), 0);
    clear_mem();
    send_frame(8'h60, -1, 0, 1'b0);
    repeat (3) tick(1'b0, 8'h00, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    check_mem("after_err", 8'h60);
    check("after_err_starts", 32'(n_start), 1);

    // Reset while beat 12 is being presented
    do_reset("rst2");
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) tick(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
    in_valid = 1'b1; in_data = 8'h7C;
    do_reset("rst_mid");
    clear_mem(); n_start = 0;
    send_frame(8'h80, -1, 0, 1'b0);
    repeat (2) tick(1'b0, 8'h00, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    check_mem("post_rst", 8'h80);
    check("post_rst_starts", 32'(n_start), 1);

    // done held during loading is ignored; done 3 cycles after start releases
    n_start = 0;
    send_frame(8'hA0, -1, 0, 1'b1);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    check("early_done_start", 32'(start), 1);
    repeat (2) tick(1'b0, 8'h00, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    check("done_ready", 32'(in_ready), 1);
    clear_mem();
    send_frame(8'hC0, -1, 20, 1'b0);
    repeat (2) tick(1'b0, 8'h00, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    check_mem("second", 8'hC0);
    check("second_starts", 32'(n_start), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
